gauss_window_sched: RTL and testbench

- Frame-level controller that sequences the 3x3 Gaussian core over a grayscale image held in a source RAM.
- Walks output pixels in raster order and fetches each 3x3 neighbourhood with single-port reads.
- Drives the core's enable and waits for its done flag, then writes the filtered result to a destination RAM.
- Writes 0 at every border pixel, so the output frame has the same size and addressing as the input.

---
 rtl/gauss_window_sched.sv | 169 ++++++++++++++++
 tb/tb_gauss_window_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_window_sched.sv
// Frame sequencer for the 3x3 Gaussian core: raster walk, 9-read window fetch,
// core handshake with timeout, destination write-back with zeroed borders.
module gauss_window_sched #(
    parameter int IMG_W        = 320,
    parameter int IMG_H        = 240,
    parameter int ADDR_W       = 17,
    parameter int CORE_TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              src_rd_o,
    output logic [ADDR_W-1:0] src_addr_o,
    input  logic [7:0]        src_data_i,
    output logic [71:0]       core_win_o,
    output logic              core_en_o,
    input  logic              core_done_i,
    input  logic [7:0]        core_data_i,
    output logic              dst_we_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [7:0]        dst_data_o
);

    // state   | meaning
    // IDLE    | waiting for start_i
    // FETCH   | issuing the nine neighbourhood reads (k = 0..8)
    // CAPT    | capturing the last read byte into slot 8
    // RUN     | core enabled, waiting for core_done_i or timeout
    // WRITE   | one destination write, then pick the next pixel
    // DONE    | one-cycle frame-complete pulse
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CAPT  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int TW = $clog2(CORE_TIMEOUT + 1);

    logic [2:0]        state_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [ADDR_W-1:0] pix_addr_q;
    logic [ADDR_W-1:0] fetch_addr_q;
    logic [3:0]        k_q;
    logic [1:0]        dx_q;
    logic [TW-1:0]     tmr_q;
    logic [71:0]       win_q;
    logic [7:0]        res_q;
    logic              err_q;

    logic [CW-1:0]     nxt_col;
    logic [RW-1:0]     nxt_row;
    logic              last_px;
    logic              nxt_border;

    always_comb begin
        nxt_col = col_q + CW'(1);
        nxt_row = row_q;
        last_px = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
        if (col_q == CW'(IMG_W - 1)) begin
            nxt_col = '0;
            nxt_row = row_q + RW'(1);
        end
        nxt_border = (nxt_row == '0) || (nxt_row == RW'(IMG_H - 1)) ||
                     (nxt_col == '0) || (nxt_col == CW'(IMG_W - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            pix_addr_q   <= '0;
            fetch_addr_q <= '0;
            k_q          <= '0;
            dx_q         <= '0;
            tmr_q        <= '0;
            win_q        <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        col_q      <= '0;
                        row_q      <= '0;
                        pix_addr_q <= '0;
                        err_q      <= 1'b0;
                        // pixel (0,0) is always a border pixel
                        res_q      <= '0;
                        state_q    <= S_WRITE;
                    end
                end
                S_FETCH: begin
                    if (k_q != 4'd0)
                        win_q <= {src_data_i, win_q[71:8]};
                    if (k_q == 4'd8) begin
                        state_q <= S_CAPT;
                    end else begin
                        k_q <= k_q + 4'd1;
                        if (dx_q == 2'd2) begin
                            dx_q         <= 2'd0;
                            fetch_addr_q <= fetch_addr_q + ADDR_W'(IMG_W - 2);
                        end else begin
                            dx_q         <= dx_q + 2'd1;
                            fetch_addr_q <= fetch_addr_q + ADDR_W'(1);
                        end
                    end
                end
                S_CAPT: begin
                    win_q   <= {src_data_i, win_q[71:8]};
                    tmr_q   <= TW'(CORE_TIMEOUT - 1);
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (core_done_i) begin
                        res_q   <= core_data_i;
                        state_q <= S_WRITE;
                    end else if (tmr_q == '0) begin
                        err_q   <= 1'b1;
                        res_q   <= '0;
                        state_q <= S_WRITE;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                S_WRITE: begin
                    if (last_px) begin
                        state_q <= S_DONE;
                    end else begin
                        col_q      <= nxt_col;
                        row_q      <= nxt_row;
                        pix_addr_q <= pix_addr_q + ADDR_W'(1);
                        if (nxt_border) begin
                            res_q   <= '0;
                            state_q <= S_WRITE;
                        end else begin
                            // top-left neighbour of the next pixel: (addr+1) - IMG_W - 1
                            fetch_addr_q <= pix_addr_q - ADDR_W'(IMG_W);
                            k_q          <= '0;
                            dx_q         <= '0;
                            state_q      <= S_FETCH;
                        end
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o     = (state_q == S_DONE);
    assign err_o      = err_q;
    assign src_rd_o   = (state_q == S_FETCH);
    assign src_addr_o = fetch_addr_q;
    assign core_win_o = win_q;
    assign core_en_o  = (state_q == S_RUN);
    assign dst_we_o   = (state_q == S_WRITE);
    assign dst_addr_o = pix_addr_q;
    assign dst_data_o = res_q;

endmodule

// File: tb/tb_gauss_window_sched.sv
// Bench for gauss_window_sched on a 4x4 frame: scoreboarded destination writes
// plus per-scenario timing, window, timeout, reset and start-hold checks.
module tb_gauss_window_sched;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 17;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          busy_o, done_o, err_o;
    logic          src_rd_o;
    logic [AW-1:0] src_addr_o;
    logic [7:0]    src_data_i;
    logic [71:0]   core_win_o;
    logic          core_en_o;
    logic          core_done_i;
    logic [7:0]    core_data_i;
    logic          dst_we_o;
    logic [AW-1:0] dst_addr_o;
    logic [7:0]    dst_data_o;

    gauss_window_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CORE_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .src_rd_o(src_rd_o), .src_addr_o(src_addr_o), .src_data_i(src_data_i),
        .core_win_o(core_win_o), .core_en_o(core_en_o),
        .core_done_i(core_done_i), .core_data_i(core_data_i),
        .dst_we_o(dst_we_o), .dst_addr_o(dst_addr_o), .dst_data_o(dst_data_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] src_mem [0:W*H-1];
    int         core_delay = 1;   // 0 = core never answers
    int         run_cnt = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         wr_cnt = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;
    wr_t exp_q[$];

    always @(posedge clk_i) begin
        if (src_rd_o) src_data_i <= src_mem[src_addr_o[3:0]];
        run_cnt <= core_en_o ? run_cnt + 1 : 0;
    end

    assign core_done_i = core_en_o && (core_delay != 0) && (run_cnt == core_delay - 1);
    assign core_data_i = core_win_o[39:32];

    // scoreboard: every destination write is matched against the expected queue
    always @(negedge clk_i) begin
        if (dst_we_o === 1'b1) begin
            wr_t e;
            wr_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL dst_write unexpected: addr=%0d data=%0d, required no write",
                         dst_addr_o, dst_data_o);
            end else begin
                e = exp_q.pop_front();
                if (dst_addr_o !== e.a || dst_data_o !== e.d)
                    $display("FAIL dst_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             dst_addr_o, dst_data_o, e.a, e.d);
                else
                    n_pass++;
            end
        end
    end

    task automatic push_frame(input bit normal);
        for (int a = 0; a < W*H; a++) begin
            wr_t e;
            int r, c;
            bit inner;
            r = a / W;
            c = a % W;
            inner = (r > 0) && (r < H-1) && (c > 0) && (c < W-1);
            e.a = AW'(a);
            e.d = (inner && normal) ? src_mem[a] : 8'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame(output int cyc);
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(inout int cyc, input int limit);
        while (done_o !== 1'b1 && cyc < limit) begin
            @(negedge clk_i);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({busy_o, done_o, err_o, src_rd_o, core_en_o, dst_we_o} !== 6'b0)
            $display("FAIL reset_flags: got %b, required 000000",
                     {busy_o, done_o, err_o, src_rd_o, core_en_o, dst_we_o});
        else n_pass++;
        n_checks++;
        if (core_win_o !== 72'd0)
            $display("FAIL reset_window: got %h, required 0", core_win_o);
        else n_pass++;
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0 || dst_we_o !== 1'b0)
            $display("FAIL idle_after_reset: busy=%b we=%b, required 0 0", busy_o, dst_we_o);
        else n_pass++;
    endtask

    task automatic test_frame();
        int cyc, n_rd, n_en;
        core_delay = 1;
        push_frame(1'b1);
        start_frame(cyc);
        n_checks++;
        if (busy_o !== 1'b1)
            $display("FAIL busy_after_start: got %b, required 1", busy_o);
        else n_pass++;
        n_rd = 0;
        n_en = 0;
        while (done_o !== 1'b1 && cyc < 500) begin
            if (src_rd_o === 1'b1) n_rd++;
            if (core_en_o === 1'b1) n_en++;
            @(negedge clk_i);
            cyc++;
        end
        n_checks++;
        if (done_o !== 1'b1 || cyc != 61)
            $display("FAIL frame_done_cycle: done=%b at cycle %0d, required 1 at 61", done_o, cyc);
        else n_pass++;
        n_checks++;
        if (busy_o !== 1'b0 || err_o !== 1'b0)
            $display("FAIL frame_end_flags: busy=%b err=%b, required 0 0", busy_o, err_o);
        else n_pass++;
        n_checks++;
        if (n_rd != 36 || n_en != 4)
            $display("FAIL frame_strobe_counts: rd=%0d en=%0d, required 36 4", n_rd, n_en);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL frame_writes_left: got %0d, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_window_delay();
        int cyc, n_fetch, en_run, n_runs;
        logic [AW-1:0] fa [9];
        logic [71:0]   exp_win, snap;
        bit            unstable;
        core_delay = 5;
        for (int k = 0; k < 9; k++)
            exp_win[8*k +: 8] = src_mem[(k/3)*W + (k%3)];
        push_frame(1'b1);
        start_frame(cyc);
        n_fetch = 0;
        en_run = 0;
        n_runs = 0;
        unstable = 1'b0;
        snap = '0;
        while (done_o !== 1'b1 && cyc < 500) begin
            if (src_rd_o === 1'b1 && n_fetch < 9) begin
                fa[n_fetch] = src_addr_o;
                n_fetch++;
            end
            if (core_en_o === 1'b1) begin
                if (en_run == 0) snap = core_win_o;
                else if (core_win_o !== snap) unstable = 1'b1;
                if (n_runs == 0 && en_run == 0) begin
                    n_checks++;
                    if (core_win_o !== exp_win)
                        $display("FAIL first_window: got %h, required %h", core_win_o, exp_win);
                    else n_pass++;
                end
                en_run++;
            end else if (en_run != 0) begin
                n_checks++;
                if (en_run != 5)
                    $display("FAIL en_run_len pixel %0d: got %0d, required 5", n_runs, en_run);
                else n_pass++;
                n_runs++;
                en_run = 0;
            end
            @(negedge clk_i);
            cyc++;
        end
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (k >= n_fetch || fa[k] !== AW'((k/3)*W + (k%3)))
                $display("FAIL fetch_addr k=%0d: got %0d, required %0d", k, fa[k], (k/3)*W + (k%3));
            else n_pass++;
        end
        n_checks++;
        if (unstable)
            $display("FAIL window_stable: got changing window, required stable");
        else n_pass++;
        n_checks++;
        if (done_o !== 1'b1 || cyc != 77)
            $display("FAIL delay_done_cycle: done=%b at cycle %0d, required 1 at 77", done_o, cyc);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL delay_writes_left: got %0d, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_timeout();
        int cyc;
        core_delay = 0;
        push_frame(1'b0);
        start_frame(cyc);
        while (done_o !== 1'b1 && cyc < 500) begin
            if (cyc == 23) begin
                n_checks++;
                if (err_o !== 1'b0) $display("FAIL err_before_timeout: got %b, required 0", err_o);
                else n_pass++;
            end
            if (cyc == 24) begin
                n_checks++;
                if (err_o !== 1'b1) $display("FAIL err_after_timeout: got %b, required 1", err_o);
                else n_pass++;
            end
            @(negedge clk_i);
            cyc++;
        end
        n_checks++;
        if (done_o !== 1'b1 || cyc != 89)
            $display("FAIL timeout_done_cycle: done=%b at cycle %0d, required 1 at 89", done_o, cyc);
        else n_pass++;
        @(negedge clk_i);
        n_checks++;
        if (err_o !== 1'b1) $display("FAIL err_sticky_idle: got %b, required 1", err_o);
        else n_pass++;
        core_delay = 1;
        push_frame(1'b1);
        start_frame(cyc);
        n_checks++;
        if (err_o !== 1'b0) $display("FAIL err_clear_on_start: got %b, required 0", err_o);
        else n_pass++;
        wait_done(cyc, 500);
        n_checks++;
        if (done_o !== 1'b1 || cyc != 61)
            $display("FAIL rerun_done_cycle: done=%b at cycle %0d, required 1 at 61", done_o, cyc);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc, w0;
        core_delay = 1;
        push_frame(1'b1);
        start_frame(cyc);
        while (core_en_o !== 1'b1 && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
        end
        n_checks++;
        if (core_en_o !== 1'b1 || cyc != 16)
            $display("FAIL pixel5_run_cycle: en=%b at cycle %0d, required 1 at 16", core_en_o, cyc);
        else n_pass++;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        n_checks++;
        if ({busy_o, done_o, src_rd_o, core_en_o, dst_we_o} !== 5'b0)
            $display("FAIL mid_reset_idle: got %b, required 00000",
                     {busy_o, done_o, src_rd_o, core_en_o, dst_we_o});
        else n_pass++;
        exp_q.delete();
        w0 = wr_cnt;
        repeat (20) @(negedge clk_i);
        n_checks++;
        if (wr_cnt != w0 || busy_o !== 1'b0)
            $display("FAIL no_writes_after_reset: writes=%0d busy=%b, required 0 0", wr_cnt - w0, busy_o);
        else n_pass++;
        push_frame(1'b1);
        start_frame(cyc);
        n_checks++;
        if (dst_we_o !== 1'b1 || dst_addr_o !== '0)
            $display("FAIL restart_addr: we=%b addr=%0d, required 1 0", dst_we_o, dst_addr_o);
        else n_pass++;
        wait_done(cyc, 500);
        n_checks++;
        if (done_o !== 1'b1 || cyc != 61)
            $display("FAIL restart_done_cycle: done=%b at cycle %0d, required 1 at 61", done_o, cyc);
        else n_pass++;
    endtask

    task automatic test_start_held();
        int cyc;
        core_delay = 1;
        push_frame(1'b1);
        push_frame(1'b1);
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        cyc = 1;
        wait_done(cyc, 500);
        n_checks++;
        if (done_o !== 1'b1 || cyc != 61)
            $display("FAIL held_first_done: done=%b at cycle %0d, required 1 at 61", done_o, cyc);
        else n_pass++;
        @(negedge clk_i);
        cyc++;
        n_checks++;
        if (busy_o !== 1'b0 || dst_we_o !== 1'b0)
            $display("FAIL held_idle_gap: busy=%b we=%b, required 0 0", busy_o, dst_we_o);
        else n_pass++;
        @(negedge clk_i);
        cyc++;
        start_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1 || dst_we_o !== 1'b1 || dst_addr_o !== '0)
            $display("FAIL held_restart: busy=%b we=%b addr=%0d, required 1 1 0",
                     busy_o, dst_we_o, dst_addr_o);
        else n_pass++;
        wait_done(cyc, 500);
        n_checks++;
        if (done_o !== 1'b1 || cyc != 123)
            $display("FAIL held_second_done: done=%b at cycle %0d, required 1 at 123", done_o, cyc);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL held_writes_left: got %0d, required 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < W*H; i++) src_mem[i] = 8'(i + 1);
        src_data_i = 8'd0;
        test_reset();
        test_frame();
        test_window_delay();
        test_timeout();
        test_reset_mid();
        test_start_held();
        repeat (3) @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
